// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and imem.
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRData;

  modport master (output ImemReq, output ImemAddr, input ImemAck, input ImemRData);
  modport slave  (input ImemReq, input ImemAddr, output ImemAck, output ImemRData);
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, ready/ack imem port, IF/ID register with
// decode redirects, hazard stalls and squashing of late wrong-path responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic [31:0]        PCBranchD,
  input  logic               JumpRegD,
  input  logic [31:0]        JRTargetD,
  fetch_stage_if.master      imem,
  output logic [31:0]        InstrD,
  output logic [31:0]        PCPlus4D,
  output logic               ValidD,
  output logic [31:0]        PCF,
  output logic               FetchBusyF
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic        hold_f;
  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign hold_f   = StallF | StallD;
  assign redir    = (JumpRegD | PCSrcD) & ~StallD;
  assign target   = JumpRegD ? JRTargetD : PCBranchD;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pcplus4_d    = pcplus4_q;
    valid_d      = valid_q;
    hold_instr_d = hold_instr_q;
    drop_addr_d  = drop_addr_q;

    // Any cycle that does not deliver an instruction inserts a bubble unless decode is frozen.
    if (!StallD) begin
      instr_d   = 32'h0;
      pcplus4_d = 32'h0;
      valid_d   = 1'b0;
    end

    case (state_q)
      FETCH: begin
        if (redir) begin
          pc_d = target;
          if (!imem.ImemAck) begin
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end else if (imem.ImemAck && !hold_f) begin
          pc_d      = pc_plus4;
          instr_d   = imem.ImemRData;
          pcplus4_d = pc_plus4;
          valid_d   = 1'b1;
        end else if (imem.ImemAck) begin
          hold_instr_d = imem.ImemRData;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!hold_f) begin
          instr_d   = hold_instr_q;
          pcplus4_d = pc_plus4;
          valid_d   = 1'b1;
          pc_d      = pc_plus4;
          state_d   = FETCH;
        end else begin
          // Parked instruction waits; IF/ID keeps whatever it already holds.
          instr_d   = instr_q;
          pcplus4_d = pcplus4_q;
          valid_d   = valid_q;
        end
      end
      DROP: begin
        if (redir) pc_d = target;
        if (imem.ImemAck) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      pcplus4_q    <= 32'h0;
      valid_q      <= 1'b0;
      hold_instr_q <= 32'h0;
      drop_addr_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pcplus4_q    <= pcplus4_d;
      valid_q      <= valid_d;
      hold_instr_q <= hold_instr_d;
      drop_addr_q  <= drop_addr_d;
    end
  end

  // A DROP keeps the abandoned address on the bus so the pending response can retire.
  assign imem.ImemReq  = ~reset & (state_q != HOLD);
  assign imem.ImemAddr = (state_q == DROP) ? drop_addr_q : pc_q;
  assign FetchBusyF    = imem.ImemReq & ~imem.ImemAck;

  assign InstrD   = instr_q;
  assign PCPlus4D = pcplus4_q;
  assign ValidD   = valid_q;
  assign PCF      = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem word at address a is 0x2000_0000 + (a >> 2).
module tb_fetch_stage;

  logic        CLK;
  logic        reset;
  logic        StallF, StallD, PCSrcD, JumpRegD;
  logic [31:0] PCBranchD, JRTargetD;
  logic [31:0] InstrD, PCPlus4D, PCF;
  logic        ValidD, FetchBusyF;
  logic        ack_en;

  int checks   = 0;
  int failures = 0;

  fetch_stage_if bus ();

  assign bus.ImemAck   = ack_en & bus.ImemReq;
  assign bus.ImemRData = bus.ImemAck ? (32'h2000_0000 + (bus.ImemAddr >> 2)) : 32'hDEAD_BEEF;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .reset(reset), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpRegD(JumpRegD), .JRTargetD(JRTargetD),
    .imem(bus.master), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .PCF(PCF), .FetchBusyF(FetchBusyF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpRegD = 1'b0;
    PCBranchD = 32'h0; JRTargetD = 32'h0; ack_en = 1'b0;
    #2;
    chk("rst_req", {31'h0, bus.ImemReq}, 32'h0);
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_pc4", PCPlus4D, 32'h0);
    chk("rst_valid", {31'h0, ValidD}, 32'h0);

    @(negedge CLK);
    reset = 1'b0; ack_en = 1'b1;
    #1;
    chk("first_req", {31'h0, bus.ImemReq}, 32'h1);
    chk("first_addr", bus.ImemAddr, 32'h0);
    chk("first_busy", {31'h0, FetchBusyF}, 32'h0);

    // Zero-wait streaming
    tick(); #1;
    chk("s0_instr", InstrD, 32'h2000_0000);
    chk("s0_pc4", PCPlus4D, 32'h4);
    chk("s0_valid", {31'h0, ValidD}, 32'h1);
    chk("s0_addr", bus.ImemAddr, 32'h4);
    tick(); #1;
    chk("s1_instr", InstrD, 32'h2000_0001);
    chk("s1_pc4", PCPlus4D, 32'h8);
    chk("s1_addr", bus.ImemAddr, 32'h8);

    // Stall both stages for two cycles at PC=8
    StallF = 1'b1; StallD = 1'b1;
    tick(); #1;
    chk("st0_pcf", PCF, 32'h8);
    chk("st0_req", {31'h0, bus.ImemReq}, 32'h0);
    chk("st0_instr", InstrD, 32'h2000_0001);
    chk("st0_pc4", PCPlus4D, 32'h8);
    tick(); #1;
    chk("st1_pcf", PCF, 32'h8);
    chk("st1_req", {31'h0, bus.ImemReq}, 32'h0);
    chk("st1_instr", InstrD, 32'h2000_0001);
    StallF = 1'b0; StallD = 1'b0;
    tick(); #1;
    chk("rel_instr", InstrD, 32'h2000_0002);
    chk("rel_pc4", PCPlus4D, 32'hC);
    chk("rel_pcf", PCF, 32'hC);
    chk("rel_addr", bus.ImemAddr, 32'hC);
    tick(); #1;
    chk("s3_instr", InstrD, 32'h2000_0003);
    chk("s3_pcf", PCF, 32'h10);

    // Taken branch to 0x40
    PCSrcD = 1'b1; PCBranchD = 32'h40;
    tick();
    PCSrcD = 1'b0; #1;
    chk("br_bub_valid", {31'h0, ValidD}, 32'h0);
    chk("br_bub_instr", InstrD, 32'h0);
    chk("br_addr", bus.ImemAddr, 32'h40);
    tick(); #1;
    chk("br_instr", InstrD, 32'h2000_0010);
    chk("br_pc4", PCPlus4D, 32'h44);
    chk("br_valid", {31'h0, ValidD}, 32'h1);

    // jr has priority over a concurrent branch
    JumpRegD = 1'b1; JRTargetD = 32'h80; PCSrcD = 1'b1; PCBranchD = 32'h40;
    tick();
    JumpRegD = 1'b0; PCSrcD = 1'b0; #1;
    chk("jr_addr", bus.ImemAddr, 32'h80);
    chk("jr_bub_valid", {31'h0, ValidD}, 32'h0);
    tick(); #1;
    chk("jr_instr", InstrD, 32'h2000_0020);
    chk("jr_pc4", PCPlus4D, 32'h84);

    // Ack delayed three cycles at 0x84
    ack_en = 1'b0; #1;
    chk("lat0_busy", {31'h0, FetchBusyF}, 32'h1);
    chk("lat0_addr", bus.ImemAddr, 32'h84);
    tick(); #1;
    chk("lat1_busy", {31'h0, FetchBusyF}, 32'h1);
    chk("lat1_addr", bus.ImemAddr, 32'h84);
    chk("lat1_valid", {31'h0, ValidD}, 32'h0);
    tick(); #1;
    chk("lat2_busy", {31'h0, FetchBusyF}, 32'h1);
    chk("lat2_addr", bus.ImemAddr, 32'h84);
    chk("lat2_valid", {31'h0, ValidD}, 32'h0);
    tick();
    ack_en = 1'b1; #1;
    chk("lat3_busy", {31'h0, FetchBusyF}, 32'h0);
    chk("lat3_valid", {31'h0, ValidD}, 32'h0);
    tick(); #1;
    chk("lat_instr", InstrD, 32'h2000_0021);
    chk("lat_pc4", PCPlus4D, 32'h88);
    chk("lat_valid", {31'h0, ValidD}, 32'h1);

    // Move to 0x20, then redirect to 0x100 while 0x20 is unacked
    PCSrcD = 1'b1; PCBranchD = 32'h20;
    tick();
    PCBranchD = 32'h100; ack_en = 1'b0; #1;
    chk("drp_addr0", bus.ImemAddr, 32'h20);
    chk("drp_busy0", {31'h0, FetchBusyF}, 32'h1);
    tick();
    PCSrcD = 1'b0; #1;
    chk("drp_addr1", bus.ImemAddr, 32'h20);
    chk("drp_pcf", PCF, 32'h100);
    chk("drp_req", {31'h0, bus.ImemReq}, 32'h1);
    chk("drp_valid1", {31'h0, ValidD}, 32'h0);
    tick();
    ack_en = 1'b1; #1;
    chk("drp_addr2", bus.ImemAddr, 32'h20);
    chk("drp_busy2", {31'h0, FetchBusyF}, 32'h0);
    tick(); #1;
    chk("drp_squash_valid", {31'h0, ValidD}, 32'h0);
    chk("drp_squash_instr", InstrD, 32'h0);
    chk("drp_new_addr", bus.ImemAddr, 32'h100);
    tick(); #1;
    chk("tgt_instr", InstrD, 32'h2000_0040);
    chk("tgt_pc4", PCPlus4D, 32'h104);

    // Redirect under StallD is ignored
    PCSrcD = 1'b1; PCBranchD = 32'h200; StallD = 1'b1;
    tick();
    PCSrcD = 1'b0; StallD = 1'b0; #1;
    chk("sd_pcf", PCF, 32'h104);
    chk("sd_instr", InstrD, 32'h2000_0040);
    tick(); #1;
    chk("sd_rel_instr", InstrD, 32'h2000_0041);
    chk("sd_rel_pc4", PCPlus4D, 32'h108);
    chk("sd_rel_pcf", PCF, 32'h108);

    // PC wrap at the top of the address space
    PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
    tick();
    PCSrcD = 1'b0; #1;
    chk("wrap_addr0", bus.ImemAddr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("wrap_pc4", PCPlus4D, 32'h0);
    chk("wrap_instr", InstrD, 32'h5FFF_FFFF);
    chk("wrap_addr1", bus.ImemAddr, 32'h0);

    // Async reset while in DROP
    ack_en = 1'b0; PCSrcD = 1'b1; PCBranchD = 32'h300;
    tick();
    PCSrcD = 1'b0; #1;
    chk("ar_drop_addr", bus.ImemAddr, 32'h0);
    chk("ar_drop_pcf", PCF, 32'h300);
    #2 reset = 1'b1;
    #1;
    chk("ar_pcf", PCF, 32'h0);
    chk("ar_req", {31'h0, bus.ImemReq}, 32'h0);
    chk("ar_valid", {31'h0, ValidD}, 32'h0);
    chk("ar_instr", InstrD, 32'h0);
    tick();
    reset = 1'b0; ack_en = 1'b1; #1;
    chk("ar_rel_req", {31'h0, bus.ImemReq}, 32'h1);
    chk("ar_rel_addr", bus.ImemAddr, 32'h0);
    tick(); #1;
    chk("ar_rel_instr", InstrD, 32'h2000_0000);
    chk("ar_rel_pc4", PCPlus4D, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
